multicycle_control: RTL and testbench

Multicycle control unit for the MIPS32 datapath. It is a Moore/Mealy state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a variable-latency memory through a ready handshake, with a configurable timeout. It traps illegal opcodes and counts retired instructions, and it sits between the instruction register and the shared multicycle datapath.

---
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on a ready-handshake memory with timeout, traps illegal opcodes, counts retires.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Run,
    input  logic [5:0]           Opcode,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 PCWriteCondNe,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemToReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           PCSource,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic                 Exception,
    output logic                 Fault,
    output logic [3:0]           State,
    output logic [CNT_WIDTH-1:0] InstrCount
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD    = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  RTYPE_EX = 4'd7,
        IMM_EX   = 4'd8,  ALU_WB = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
        TRAP     = 4'd12, HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, nxt;
    ctl_t              ctl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting, timeout, retire, fetch_rdy;

    // Controls for the state being entered, so the outputs come straight from flops.
    function automatic ctl_t decode(state_t s, logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            DECODE:   c.alu_src_b = 2'b11;
            MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEMRD:    begin c.mem_read = 1'b1; c.iord = 1'b1; end
            MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            MEMWR:    begin c.mem_write = 1'b1; c.iord = 1'b1; end
            RTYPE_EX: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            IMM_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = (op == OP_SLTI) ? 2'b11 : 2'b00;
            end
            ALU_WB:   begin c.reg_write = 1'b1; c.reg_dst = (op == OP_RTYPE); end
            BRANCH: begin
                c.alu_src_a        = 1'b1;
                c.alu_op           = 2'b01;
                c.pc_source        = 2'b01;
                c.pc_write_cond    = (op == OP_BEQ);
                c.pc_write_cond_ne = (op == OP_BNE);
            end
            JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            TRAP:     begin c.pc_write = 1'b1; c.pc_source = 2'b11; end
            default:  ;
        endcase
        return c;
    endfunction

    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !MemReady;
    assign timeout = waiting && (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            IDLE:     if (Run) nxt = FETCH;
            FETCH:    if (MemReady) nxt = DECODE; else if (timeout) nxt = HALT;
            DECODE: begin
                case (Opcode)
                    OP_RTYPE:        nxt = RTYPE_EX;
                    OP_LW, OP_SW:    nxt = MEMADR;
                    OP_BEQ, OP_BNE:  nxt = BRANCH;
                    OP_J:            nxt = JUMP;
                    OP_ADDI, OP_SLTI: nxt = IMM_EX;
                    default:         nxt = TRAP;
                endcase
            end
            MEMADR:   nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (MemReady) nxt = MEMWB; else if (timeout) nxt = HALT;
            MEMWR:    if (MemReady) retire = 1'b1; else if (timeout) nxt = HALT;
            RTYPE_EX, IMM_EX: nxt = ALU_WB;
            MEMWB, ALU_WB, BRANCH, JUMP: retire = 1'b1;
            TRAP:     nxt = FETCH;
            HALT:     nxt = HALT;
            default:  nxt = IDLE;
        endcase
        // Run only matters at instruction boundaries; an in-flight instruction always finishes.
        if (retire) nxt = Run ? FETCH : IDLE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            ctl_q      <= '0;
            Exception  <= 1'b0;
            Fault      <= 1'b0;
            InstrCount <= '0;
            wait_cnt   <= '0;
        end else begin
            state     <= nxt;
            ctl_q     <= decode(nxt, Opcode);
            Exception <= (nxt == TRAP);
            if (nxt == HALT) Fault <= 1'b1;
            if (retire) InstrCount <= InstrCount + 1'b1;
            if (nxt != state)
                wait_cnt <= '0;
            else if (waiting && TIMEOUT_CYCLES != 0)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The IR load and PC increment in FETCH follow MemReady within the same cycle.
    assign fetch_rdy     = (state == FETCH) && MemReady;
    assign PCWrite       = ctl_q.pc_write | fetch_rdy;
    assign IRWrite       = fetch_rdy;
    assign PCWriteCond   = ctl_q.pc_write_cond;
    assign PCWriteCondNe = ctl_q.pc_write_cond_ne;
    assign IorD          = ctl_q.iord;
    assign MemRead       = ctl_q.mem_read;
    assign MemWrite      = ctl_q.mem_write;
    assign MemToReg      = ctl_q.mem_to_reg;
    assign RegDst        = ctl_q.reg_dst;
    assign RegWrite      = ctl_q.reg_write;
    assign ALUSrcA       = ctl_q.alu_src_a;
    assign PCSource      = ctl_q.pc_source;
    assign ALUSrcB       = ctl_q.alu_src_b;
    assign ALUOp         = ctl_q.alu_op;
    assign State         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances (timeout 15/4/0, counter 16/2/16) share inputs;
// a per-cycle vector table drives the main flow, hand sequences cover timeout, wrap and reset.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Rst_n, Run, MemReady;
    logic [5:0] Opcode;

    always #5 Clk = ~Clk;

    // ctl bit order: PCWrite,PCWriteCond,PCWriteCondNe,IorD,MemRead,MemWrite,IRWrite,
    // MemToReg,RegDst,RegWrite,ALUSrcA,PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0]
    logic [16:0] ctl [3];
    logic [3:0]  st  [3];
    logic        exc [3];
    logic        flt [3];
    logic [15:0] cnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TO = (g == 0) ? 15 : (g == 1) ? 4 : 0;
        localparam int CW = (g == 1) ? 2 : 16;
        logic pcw, pcwc, pcwcn, iord, mrd, mwr, irw, m2r, rdst, rw, asa, e, f;
        logic [1:0] pcs, asb, aop;
        logic [3:0] s;
        logic [CW-1:0] ic;
        multicycle_control #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) u_dut (
            .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
            .PCWrite(pcw), .PCWriteCond(pcwc), .PCWriteCondNe(pcwcn), .IorD(iord),
            .MemRead(mrd), .MemWrite(mwr), .IRWrite(irw), .MemToReg(m2r), .RegDst(rdst),
            .RegWrite(rw), .ALUSrcA(asa), .PCSource(pcs), .ALUSrcB(asb), .ALUOp(aop),
            .Exception(e), .Fault(f), .State(s), .InstrCount(ic)
        );
        assign ctl[g] = {pcw, pcwc, pcwcn, iord, mrd, mwr, irw, m2r, rdst, rw, asa, pcs, asb, aop};
        assign st[g]  = s;
        assign exc[g] = e;
        assign flt[g] = f;
        assign cnt[g] = 16'(ic);
    end

    localparam logic [16:0] C_IDLE = 17'h00000, C_FETCH_W = 17'h01004, C_FETCH_R = 17'h11404,
        C_DEC = 17'h0000C, C_MEMADR = 17'h00048, C_MEMRD = 17'h03000, C_MEMWB = 17'h00280,
        C_MEMWR = 17'h02800, C_RTYPE = 17'h00042, C_ADDI = 17'h00048, C_SLTI = 17'h0004B,
        C_WB_R = 17'h00180, C_WB_I = 17'h00080, C_BEQ = 17'h08051, C_BNE = 17'h04051,
        C_JUMP = 17'h10020, C_TRAP = 17'h10030;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011,
        O_BEQ = 6'b000100, O_BNE = 6'b000101, O_J = 6'b000010, O_ADDI = 6'b001000,
        O_SLTI = 6'b001010, O_ILL = 6'b111111;

    typedef struct {
        logic        run;
        logic        rdy;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        exc;
        logic [15:0] cnt;
    } vec_t;

    vec_t v[$];
    int   checks = 0;
    int   errors = 0;
    int   hk[3];

    function automatic vec_t mk(logic run, logic rdy, logic [5:0] op, logic [3:0] s,
                                logic [16:0] c, logic e, logic [15:0] n);
        vec_t r;
        r.run = run; r.rdy = rdy; r.op = op; r.st = s; r.ctl = c; r.exc = e; r.cnt = n;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Run = 1'b0; MemReady = 1'b0; Opcode = O_R;
        @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n = 1'b0; Run = 1'b0; MemReady = 1'b0; Opcode = O_R;
        #12;
        chk("reset_state", st[0], 0);
        chk("reset_ctl", ctl[0], 0);
        chk("reset_exc", exc[0], 0);
        chk("reset_fault", flt[0], 0);
        chk("reset_cnt", cnt[0], 0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // run, rdy, opcode, expected state, ctl, exception, count (observed this cycle)
        v.push_back(mk(1, 1, O_R,    0,  C_IDLE,    0, 0));
        v.push_back(mk(1, 1, O_R,    1,  C_FETCH_R, 0, 0));
        v.push_back(mk(1, 1, O_R,    2,  C_DEC,     0, 0));
        v.push_back(mk(1, 1, O_R,    7,  C_RTYPE,   0, 0));
        v.push_back(mk(1, 1, O_R,    9,  C_WB_R,    0, 0));
        v.push_back(mk(1, 1, O_LW,   1,  C_FETCH_R, 0, 1));
        v.push_back(mk(1, 1, O_LW,   2,  C_DEC,     0, 1));
        v.push_back(mk(1, 1, O_LW,   3,  C_MEMADR,  0, 1));
        v.push_back(mk(1, 0, O_LW,   4,  C_MEMRD,   0, 1));
        v.push_back(mk(1, 0, O_LW,   4,  C_MEMRD,   0, 1));
        v.push_back(mk(1, 0, O_LW,   4,  C_MEMRD,   0, 1));
        v.push_back(mk(1, 1, O_LW,   4,  C_MEMRD,   0, 1));
        v.push_back(mk(1, 1, O_LW,   5,  C_MEMWB,   0, 1));
        v.push_back(mk(1, 1, O_SW,   1,  C_FETCH_R, 0, 2));
        v.push_back(mk(1, 1, O_SW,   2,  C_DEC,     0, 2));
        v.push_back(mk(1, 1, O_SW,   3,  C_MEMADR,  0, 2));
        v.push_back(mk(1, 0, O_SW,   6,  C_MEMWR,   0, 2));
        v.push_back(mk(1, 1, O_SW,   6,  C_MEMWR,   0, 2));
        v.push_back(mk(1, 1, O_SLTI, 1,  C_FETCH_R, 0, 3));
        v.push_back(mk(1, 1, O_SLTI, 2,  C_DEC,     0, 3));
        v.push_back(mk(1, 1, O_SLTI, 8,  C_SLTI,    0, 3));
        v.push_back(mk(1, 1, O_SLTI, 9,  C_WB_I,    0, 3));
        v.push_back(mk(1, 1, O_ADDI, 1,  C_FETCH_R, 0, 4));
        v.push_back(mk(1, 1, O_ADDI, 2,  C_DEC,     0, 4));
        v.push_back(mk(1, 1, O_ADDI, 8,  C_ADDI,    0, 4));
        v.push_back(mk(1, 1, O_ADDI, 9,  C_WB_I,    0, 4));
        v.push_back(mk(1, 1, O_BEQ,  1,  C_FETCH_R, 0, 5));
        v.push_back(mk(1, 1, O_BEQ,  2,  C_DEC,     0, 5));
        v.push_back(mk(1, 1, O_BEQ,  10, C_BEQ,     0, 5));
        v.push_back(mk(1, 1, O_J,    1,  C_FETCH_R, 0, 6));
        v.push_back(mk(1, 1, O_J,    2,  C_DEC,     0, 6));
        v.push_back(mk(1, 1, O_J,    11, C_JUMP,    0, 6));
        v.push_back(mk(1, 1, O_ILL,  1,  C_FETCH_R, 0, 7));
        v.push_back(mk(1, 1, O_ILL,  2,  C_DEC,     0, 7));
        v.push_back(mk(1, 1, O_ILL,  12, C_TRAP,    1, 7));
        v.push_back(mk(1, 1, O_BNE,  1,  C_FETCH_R, 0, 7));
        v.push_back(mk(1, 1, O_BNE,  2,  C_DEC,     0, 7));
        v.push_back(mk(0, 1, O_BNE,  10, C_BNE,     0, 7));
        v.push_back(mk(0, 1, O_R,    0,  C_IDLE,    0, 8));
        v.push_back(mk(1, 1, O_R,    0,  C_IDLE,    0, 8));
        v.push_back(mk(1, 0, O_R,    1,  C_FETCH_W, 0, 8));
        v.push_back(mk(0, 1, O_R,    1,  C_FETCH_R, 0, 8));
        v.push_back(mk(0, 1, O_R,    2,  C_DEC,     0, 8));
        v.push_back(mk(0, 1, O_R,    7,  C_RTYPE,   0, 8));
        v.push_back(mk(0, 1, O_R,    9,  C_WB_R,    0, 8));
        v.push_back(mk(0, 1, O_R,    0,  C_IDLE,    0, 9));

        foreach (v[i]) begin
            Run = v[i].run; MemReady = v[i].rdy; Opcode = v[i].op;
            @(negedge Clk);
            chk($sformatf("vec%0d_state", i), st[0], v[i].st);
            chk($sformatf("vec%0d_ctl", i), ctl[0], v[i].ctl);
            chk($sformatf("vec%0d_exc", i), exc[0], v[i].exc);
            chk($sformatf("vec%0d_cnt", i), cnt[0], v[i].cnt);
            @(posedge Clk);
            #1;
        end
        chk("table_cnt_w2", cnt[1], 1);
        chk("table_cnt_t0", cnt[2], 9);
        chk("table_no_fault", flt[1], 0);

        // Fetch stuck: limit 4 halts on cycle 5, limit 15 on cycle 16, limit 0 never.
        do_reset();
        Run = 1'b1;
        hk = '{0, 0, 0};
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            for (int g = 0; g < 3; g++)
                if (hk[g] == 0 && st[g] == 4'd13) hk[g] = k;
            @(posedge Clk);
            #1;
        end
        chk("halt_cycle_to4", hk[1], 5);
        chk("halt_cycle_to15", hk[0], 16);
        chk("halt_cycle_to0", hk[2], 0);
        chk("to0_still_fetch", st[2], 1);
        chk("fault_to4", flt[1], 1);
        chk("fault_to15", flt[0], 1);
        chk("fault_to0", flt[2], 0);
        chk("halt_ctl", ctl[1], 0);
        MemReady = 1'b1;
        cyc(3);
        chk("halt_sticky_state", st[1], 13);
        chk("halt_sticky_fault", flt[1], 1);
        Rst_n = 1'b0;
        #1;
        chk("fault_cleared", flt[1], 0);
        chk("halt_reset_state", st[1], 0);

        // Ready arriving in the cycle the wait counter hits the limit completes the access.
        do_reset();
        Run = 1'b1;
        cyc(1);
        cyc(3);
        MemReady = 1'b1;
        cyc(1);
        @(negedge Clk);
        chk("limit_ready_state", st[1], 2);
        chk("limit_ready_fault", flt[1], 0);

        // Two-bit counter wraps after four retires.
        do_reset();
        Run = 1'b1; MemReady = 1'b1; Opcode = O_J;
        cyc(1);
        cyc(9);
        @(negedge Clk);
        chk("wrap_pre_w2", cnt[1], 3);
        chk("wrap_pre_state", st[1], 1);
        cyc(3);
        chk("wrap_w2", cnt[1], 0);
        chk("wrap_w16", cnt[0], 4);

        // Async reset while a store is outstanding.
        do_reset();
        Run = 1'b1; MemReady = 1'b1; Opcode = O_SW;
        cyc(1);
        cyc(3);
        MemReady = 1'b0;
        @(negedge Clk);
        chk("memwr_state", st[0], 6);
        chk("memwr_ctl", ctl[0], C_MEMWR);
        #2 Rst_n = 1'b0;
        #1;
        chk("async_rst_state", st[0], 0);
        chk("async_rst_ctl", ctl[0], 0);
        chk("async_rst_exc", exc[0], 0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
